// File: rtl/coin_event_arbiter_if.sv
// coin_event_arbiter_if
//   MMIO-side bundle between the coin event arbiter and the CPU read decode.
//   Ports carried:
//     rd_en        CPU -> arbiter  one-cycle pop strobe
//     clr          CPU -> arbiter  synchronous flush
//     event_data   arbiter -> CPU  head of event FIFO (fall-through)
//     event_valid  arbiter -> CPU  FIFO not empty
//     fifo_count   arbiter -> CPU  entries held
//     overflow     arbiter -> CPU  sticky lost-event flag
//     total_cents  arbiter -> CPU  saturating running sum of pushed cents
//   master = CPU side, slave = arbiter side.
interface coin_event_arbiter_if;
  logic        rd_en;
  logic        clr;
  logic [31:0] event_data;
  logic        event_valid;
  logic [6:0]  fifo_count;
  logic        overflow;
  logic [15:0] total_cents;

  modport master (
    output rd_en, clr,
    input  event_data, event_valid, fifo_count, overflow, total_cents
  );

  modport slave (
    input  rd_en, clr,
    output event_data, event_valid, fifo_count, overflow, total_cents
  );
endinterface

// File: rtl/coin_event_arbiter.sv
// coin_event_arbiter
//   Turns the four beam-break sensor levels (penny, nickel, dime, quarter)
//   into a queue of coin events the CPU drains through one MMIO word.
//   Each sensor is synchronised (2 flops) and debounced; each accepted
//   rising level becomes a pending request; pending requests are granted
//   round-robin into a first-word-fall-through FIFO.
//   Ports:
//     clock     system clock
//     reset     asynchronous, active-low reset
//     beam_raw  raw sensor levels, 1 = beam broken (bit0 penny .. bit3 quarter)
//     mmio      coin_event_arbiter_if.slave (rd_en, clr in; event_data,
//               event_valid, fifo_count, overflow, total_cents out)
//   event_data: [7:0] cents, [9:8] source, [29:10] timestamp, [30] overflow,
//               [31] valid.
//   Optional feature macro: COIN_EVT_TIMESTAMP_EN adds a free-running cycle
//   counter whose low 20 bits are stamped into each event; without it the
//   timestamp field is always 0.
module coin_event_arbiter #(
  parameter int DEBOUNCE_CYCLES = 30000,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [3:0]          beam_raw,
  coin_event_arbiter_if.slave mmio
);

  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0]  DEPTH_C  = 7'(FIFO_DEPTH);

  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    deb;
  logic [15:0]   deb_cnt [4];
  logic [3:0]    rise;
  logic [3:0]    pending;
  logic [1:0]    rr;
  logic          overflow_q;
  logic [15:0]   total_q;

  logic [29:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [6:0]    count;

  logic          grant;
  logic [1:0]    grant_src;
  logic [1:0]    cand;
  logic [7:0]    grant_cents;
  logic          push;
  logic          do_pop;
  logic [3:0]    grant_mask;
  logic [16:0]   cents_sum;
  logic [19:0]   ts_now;

  function automatic logic [7:0] cents_of(input logic [1:0] src);
    case (src)
      2'd0:    cents_of = 8'd1;
      2'd1:    cents_of = 8'd5;
      2'd2:    cents_of = 8'd10;
      default: cents_of = 8'd25;
    endcase
  endfunction

`ifdef COIN_EVT_TIMESTAMP_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cycle_cnt <= '0;
    else        cycle_cnt <= cycle_cnt + 32'd1;
  end

  assign ts_now = cycle_cnt[19:0];
`else
  assign ts_now = '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= beam_raw;
      sync2 <= sync1;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive cycles of
  // disagreement with the current debounced value; any agreement restarts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 16'd1;
        end
      end
    end
  end

  // rise marks the edge on which deb goes 0 -> 1.
  always_comb begin
    rise = '0;
    for (int i = 0; i < 4; i++)
      rise[i] = sync2[i] & ~deb[i] & (deb_cnt[i] == DEB_LAST);
  end

  // Round-robin search starts just after the last granted channel.
  // A full FIFO still accepts when the same cycle pops.
  always_comb begin
    grant     = 1'b0;
    grant_src = rr;
    cand      = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = rr + 2'(k);
      if (!grant && pending[cand]) begin
        grant     = 1'b1;
        grant_src = cand;
      end
    end
    grant_cents = cents_of(grant_src);
    push        = grant && ((count < DEPTH_C) || mmio.rd_en) && !mmio.clr;
    do_pop      = mmio.rd_en && (count != 7'd0) && !mmio.clr;
    grant_mask  = push ? (4'b0001 << grant_src) : 4'b0000;
    cents_sum   = {1'b0, total_q} + {9'b0, grant_cents};
  end

  // A new rising edge on a channel whose previous event is still pending
  // is dropped and only recorded in the sticky overflow flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending    <= '0;
      overflow_q <= 1'b0;
      total_q    <= '0;
      rr         <= 2'd3;
    end else if (mmio.clr) begin
      pending    <= '0;
      overflow_q <= 1'b0;
      total_q    <= '0;
    end else begin
      pending <= (pending & ~grant_mask) | (rise & ~pending);
      if (|(rise & pending)) overflow_q <= 1'b1;
      if (push) begin
        rr      <= grant_src;
        total_q <= cents_sum[16] ? 16'hFFFF : cents_sum[15:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= {ts_now, grant_src, grant_cents};
  end

  // When full, push and pop together write into the slot being vacated.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (mmio.clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !do_pop)      count <= count + 7'd1;
      else if (!push && do_pop) count <= count - 7'd1;
    end
  end

  assign mmio.event_valid = (count != 7'd0);
  assign mmio.event_data  = (count != 7'd0) ? {1'b1, overflow_q, fifo_mem[rd_ptr]}
                                            : {1'b0, overflow_q, 30'b0};
  assign mmio.fifo_count  = count;
  assign mmio.overflow    = overflow_q;
  assign mmio.total_cents = total_q;

endmodule

// File: tb/tb_coin_event_arbiter.sv
// tb_coin_event_arbiter
//   Drives coin_event_arbiter (DEBOUNCE_CYCLES=4, FIFO_DEPTH=8) through the
//   directed scenarios and a randomized phase. A behavioural model predicts
//   every pushed event into a circular expected-event store; a monitor on
//   the falling edge pops from it whenever the CPU side pops the DUT.
module tb_coin_event_arbiter;
  localparam int DEB   = 4;
  localparam int DEPTH = 8;

  logic       clock    = 1'b0;
  logic       reset    = 1'b0;
  logic [3:0] beam_raw = 4'b0000;

  coin_event_arbiter_if bus ();

  coin_event_arbiter #(
    .DEBOUNCE_CYCLES(DEB),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .beam_raw(beam_raw),
    .mmio    (bus.slave)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int coin_value(input int ch);
    case (ch)
      0:       return 1;
      1:       return 5;
      2:       return 10;
      default: return 25;
    endcase
  endfunction

  // Expected-event store: model appends at wr_idx, monitor consumes at
  // rd_idx; entries below base were discarded by a flush or reset.
  logic [29:0] exp_mem [256];
  int wr_idx = 0;
  int rd_idx = 0;
  int base   = 0;

  logic [3:0] m_s1   = '0;
  logic [3:0] m_s2   = '0;
  logic [3:0] m_deb  = '0;
  logic [3:0] m_pend = '0;
  int         m_run [4] = '{0, 0, 0, 0};
  int         m_rr    = 3;
  bit         m_ovf   = 1'b0;
  int         m_total = 0;

  // Behavioural reference: each sensor is its input delayed two samples;
  // a changed level is believed once it has differed for DEB samples.
  always @(posedge clock or negedge reset) begin : model
    int         live_rd;
    int         pre_cnt;
    int         grant_ch;
    int         c;
    logic [3:0] rise;
    logic [3:0] old_pend;
    if (!reset) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_pend = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_rr = 3; m_ovf = 1'b0; m_total = 0;
      base = wr_idx;
    end else begin
      rise = '0;
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] != m_deb[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DEB) begin
            m_deb[i] = m_s2[i];
            m_run[i] = 0;
            if (m_s2[i]) rise[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      live_rd  = (rd_idx > base) ? rd_idx : base;
      pre_cnt  = wr_idx - live_rd;
      grant_ch = -1;
      if (pre_cnt < DEPTH || bus.rd_en) begin
        for (int k = 1; k <= 4; k++) begin
          c = (m_rr + k) % 4;
          if (grant_ch < 0 && m_pend[c]) grant_ch = c;
        end
      end
      if (bus.clr) begin
        base    = wr_idx;
        m_pend  = '0;
        m_ovf   = 1'b0;
        m_total = 0;
      end else begin
        old_pend = m_pend;
        if (grant_ch >= 0) begin
          exp_mem[wr_idx % 256] = {20'd0, 2'(grant_ch), 8'(coin_value(grant_ch))};
          wr_idx = wr_idx + 1;
          m_pend[grant_ch] = 1'b0;
          m_rr = grant_ch;
          m_total = m_total + coin_value(grant_ch);
          if (m_total > 65535) m_total = 65535;
        end
        for (int i = 0; i < 4; i++) begin
          if (rise[i]) begin
            if (old_pend[i]) m_ovf = 1'b1;
            else             m_pend[i] = 1'b1;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = beam_raw;
    end
  end

  always @(negedge clock) begin : monitor
    int live_rd;
    int n;
    live_rd = (rd_idx > base) ? rd_idx : base;
    n = wr_idx - live_rd;
    check_output("fifo_count",  32'(bus.fifo_count),  32'(n));
    check_output("event_valid", 32'(bus.event_valid), 32'(n != 0));
    check_output("overflow",    32'(bus.overflow),    32'(m_ovf));
    check_output("total_cents", 32'(bus.total_cents), 32'(m_total));
    if (n == 0)
      check_output("empty_data", bus.event_data, {1'b0, m_ovf, 30'b0});
    if (reset && bus.rd_en && n > 0) begin
      check_output("pop_data", bus.event_data, {1'b1, m_ovf, exp_mem[live_rd % 256]});
      rd_idx = live_rd + 1;
    end
  end

  task automatic apply_stimulus(input logic [3:0] b, input logic rd, input logic c, input int n);
    beam_raw  = b;
    bus.rd_en = rd;
    bus.clr   = c;
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic wait_valid(input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clock);
      #2;
      if (bus.event_valid) begin
        lat = i;
        return;
      end
    end
  endtask

  initial begin
    int         lat;
    logic [3:0] b;
    bus.rd_en = 1'b0;
    bus.clr   = 1'b0;
    repeat (3) @(posedge clock);
    #2;

    $display("[TB] single penny latency and pop");
    reset    = 1'b1;
    beam_raw = 4'b0001;
    wait_valid(50, lat);
    check_output("t1_latency", 32'(lat), 32'(DEB + 3));
    check_output("t1_data", 32'(bus.event_data[9:0]), 32'h001);
    check_output("t1_total", 32'(bus.total_cents), 32'd1);
    check_output("t1_count", 32'(bus.fifo_count), 32'd1);
    apply_stimulus(4'b0001, 1'b1, 1'b0, 1);
    check_output("t1_valid_after_pop", 32'(bus.event_valid), 32'd0);
    check_output("t1_count_after_pop", 32'(bus.fifo_count), 32'd0);
    apply_stimulus(4'b0000, 1'b0, 1'b0, 10);

    $display("[TB] dime glitch then held");
    apply_stimulus(4'b0000, 1'b0, 1'b1, 1);
    apply_stimulus(4'b0100, 1'b0, 1'b0, 3);
    apply_stimulus(4'b0000, 1'b0, 1'b0, 10);
    check_output("t2_glitch_count", 32'(bus.fifo_count), 32'd0);
    check_output("t2_glitch_total", 32'(bus.total_cents), 32'd0);
    apply_stimulus(4'b0100, 1'b0, 1'b0, 10);
    check_output("t2_count", 32'(bus.fifo_count), 32'd1);
    check_output("t2_cents", 32'(bus.event_data[7:0]), 32'd10);
    apply_stimulus(4'b0100, 1'b1, 1'b0, 1);
    apply_stimulus(4'b0000, 1'b0, 1'b0, 10);

    $display("[TB] simultaneous rise round-robin");
    reset = 1'b0;
    apply_stimulus(4'b0000, 1'b0, 1'b0, 1);
    reset = 1'b1;
    for (int rep = 0; rep < 2; rep++) begin
      apply_stimulus(4'b1111, 1'b0, 1'b0, 12);
      check_output("t3_count", 32'(bus.fifo_count), 32'd4);
      check_output("t3_total", 32'(bus.total_cents), 32'(41 * (rep + 1)));
      for (int i = 0; i < 4; i++) begin
        check_output("t3_src_order", 32'(bus.event_data[9:8]), 32'(i));
        apply_stimulus(4'b1111, 1'b1, 1'b0, 1);
      end
      apply_stimulus(4'b0000, 1'b0, 1'b0, 10);
    end

    $display("[TB] fill, pending and overflow");
    apply_stimulus(4'b0000, 1'b0, 1'b1, 1);
    for (int n = 0; n < 8; n++) begin
      apply_stimulus(4'(1 << (n % 4)), 1'b0, 1'b0, 8);
      apply_stimulus(4'b0000, 1'b0, 1'b0, 8);
    end
    check_output("t4_full", 32'(bus.fifo_count), 32'd8);
    apply_stimulus(4'b0001, 1'b0, 1'b0, 8);
    apply_stimulus(4'b0000, 1'b0, 1'b0, 8);
    check_output("t4_pending_count", 32'(bus.fifo_count), 32'd8);
    check_output("t4_no_ovf_yet", 32'(bus.overflow), 32'd0);
    apply_stimulus(4'b0001, 1'b0, 1'b0, 8);
    apply_stimulus(4'b0000, 1'b0, 1'b0, 8);
    check_output("t4_ovf", 32'(bus.overflow), 32'd1);
    check_output("t4_ovf_bit30", 32'(bus.event_data[30]), 32'd1);
    apply_stimulus(4'b0000, 1'b1, 1'b0, 1);
    check_output("t4_count_after_pop", 32'(bus.fifo_count), 32'd8);
    check_output("t4_total", 32'(bus.total_cents), 32'd83);

    $display("[TB] grant with pop while full, then flush");
    apply_stimulus(4'b0010, 1'b0, 1'b0, 8);
    apply_stimulus(4'b0000, 1'b0, 1'b0, 8);
    apply_stimulus(4'b0000, 1'b1, 1'b0, 1);
    check_output("t5_count", 32'(bus.fifo_count), 32'd8);
    check_output("t5_total", 32'(bus.total_cents), 32'd88);
    apply_stimulus(4'b0000, 1'b1, 1'b1, 1);
    check_output("t5_clr_count", 32'(bus.fifo_count), 32'd0);
    check_output("t5_clr_ovf", 32'(bus.overflow), 32'd0);
    check_output("t5_clr_total", 32'(bus.total_cents), 32'd0);
    check_output("t5_clr_data", bus.event_data, 32'd0);
    apply_stimulus(4'b0000, 1'b0, 1'b0, 2);

    $display("[TB] asynchronous reset mid-activity");
    apply_stimulus(4'b1000, 1'b0, 1'b0, 9);
    check_output("t6_pre_count", 32'(bus.fifo_count), 32'd1);
    apply_stimulus(4'b0100, 1'b0, 1'b0, 2);
    reset = 1'b0;
    #1;
    check_output("t6_rst_data", bus.event_data, 32'd0);
    check_output("t6_rst_valid", 32'(bus.event_valid), 32'd0);
    check_output("t6_rst_count", 32'(bus.fifo_count), 32'd0);
    check_output("t6_rst_ovf", 32'(bus.overflow), 32'd0);
    check_output("t6_rst_total", 32'(bus.total_cents), 32'd0);
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    wait_valid(50, lat);
    check_output("t6_latency", 32'(lat), 32'(DEB + 3));
    apply_stimulus(4'b0100, 1'b0, 1'b0, 10);
    check_output("t6_one_event", 32'(bus.fifo_count), 32'd1);
    check_output("t6_data", 32'(bus.event_data[9:0]), 32'h20A);
    apply_stimulus(4'b0000, 1'b0, 1'b0, 10);

    $display("[TB] total_cents saturation");
    apply_stimulus(4'b0000, 1'b0, 1'b1, 1);
    for (int n = 0; n < 1700; n++) begin
      apply_stimulus(4'b1111, 1'b1, 1'b0, 6);
      apply_stimulus(4'b0000, 1'b1, 1'b0, 6);
    end
    check_output("sat_total", 32'(bus.total_cents), 32'h0000FFFF);
    apply_stimulus(4'b0000, 1'b0, 1'b0, 4);

    $display("[TB] randomized traffic");
    apply_stimulus(4'b0000, 1'b0, 1'b1, 1);
    for (int n = 0; n < 3000; n++) begin
      b = beam_raw;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(7) == 0) b[i] = ~b[i];
      apply_stimulus(b, 1'($urandom_range(3) == 0), 1'($urandom_range(299) == 0), 1);
    end
    apply_stimulus(4'b0000, 1'b0, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
